wb_link_arbiter: RTL and testbench
==================================

Name: wb_link_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the single-transaction Wishbone-over-optical-link master (wb_master_be).
- Shares the master among NREQ independent requesters (AXI register bridge, calibration engine, slow-control scanner, ...).
- Sequences exactly one bus cycle at a time, retries on link/bus error and recovers hung cycles with a timeout and master reset pulse.
- Lives in the clk_link domain next to the master; requesters must already be synchronous to clk_link.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4095, clk_link cycles in ISSUE without ack before abort.
- MAX_RETRY, 2, reissues after wb_err before the error is reported.
- RECOVER_CYCLES, 16, cycles wb_reset is held high after a timeout.

Ports:
- clk_link  in  1  link clock, all logic.
- reset  in  1  synchronous, active-high.
- enable  in  1  0 = no new grants; an in-flight cycle completes normally.
- req_valid  in  NREQ  per-requester request; held until its req_done.
- req_we  in  NREQ  1 = write.
- req_target  in  5*NREQ  target field, requester i at [5i+4:5i].
- req_addr  in  18*NREQ  address, requester i at [18i+17:18i].
- req_wdata  in  32*NREQ  write data, requester i at [32i+31:32i].
- req_done  out  NREQ  one-cycle completion pulse to requester i.
- req_error  out  1  valid with req_done: 1 = failed.
- rsp_rdata  out  32  read data, valid with req_done, held until the next completion.
- rsp_code  out  2  valid with req_done: 0 ok, 1 wb_err retries exhausted, 2 timeout.
- wb_str  out  1  strobe/cyc to master.
- wb_we  out  1  write enable, qualified by wb_str.
- wb_target  out  5  latched target.
- wb_addr  out  18  latched address.
- wb_dato  out  32  latched write data.
- wb_reset  out  1  master reset.
- wb_ack  in  1  master ack.
- wb_err  in  1  master error pulse.
- wb_dati  in  32  master read data, valid with wb_ack.
- busy  out  1  state != IDLE.
- owner  out  3  index of the granted requester.
- timeout_count  out  16  saturating count of timeouts.
- retry_count  out  16  saturating count of retries.

Behaviour:
- Reset values:
  - State IDLE; all outputs 0.
  - Priority pointer 0.
  - Counters 0.
  - rsp_rdata 0.
- States:
  - IDLE: if enable and any req_valid, grant the first requester at or after the pointer (round-robin, wrapping NREQ-1 -> 0). Latch we/target/addr/wdata into wb_* registers, set owner, clear the retry counter, go ISSUE. wb_str rises the cycle after the grant decision.
  - ISSUE: wb_str=1 and wb_we=latched we. A 12-bit-plus duration counter increments each cycle.
    - wb_err has priority over wb_ack when both are seen in the same cycle.
    - On wb_err: if retries < MAX_RETRY, increment retries and retry_count, then go GAP. Otherwise complete with code 1.
    - On wb_ack alone: latch wb_dati into rsp_rdata, complete with code 0.
    - On counter == TIMEOUT_CYCLES-1 with no ack/err: increment timeout_count, go RECOVER.
  - GAP: wb_str=0 for exactly 1 cycle, then ISSUE again with the same latched fields. No re-arbitration.
  - RECOVER: wb_str=0, wb_reset=1 for RECOVER_CYCLES cycles, then complete with code 2.
  - Complete: pulse req_done[owner] for 1 cycle, drive req_error and rsp_code alongside it. Set the pointer to owner+1 (mod NREQ), go IDLE.
- Latency and data:
  - wb_str drops the cycle after ack/err. req_done is asserted in that same cycle.
  - Read path (first ack): grant -> req_done = 1 + ack latency + 1 cycles.
  - rsp_rdata is updated only on a successful read. Writes and errors leave it unchanged.
- Boundary conditions:
  - The earliest re-grant is the cycle after req_done, so wb_str is low for at least 1 cycle between transactions.
  - Dropping req_valid mid-transaction is ignored: the cycle runs to completion and req_done still pulses.
  - enable deasserted mid-transaction does not abort the transaction.
  - req_valid changes on non-owners never disturb the latched fields.
  - Counters saturate at 16'hFFFF and clear only on reset.
  - reset mid-operation: next cycle everything returns to reset values. wb_str falls immediately (registered). No req_done is issued for the aborted cycle.

Test Plan:
- Single read from req 0 (target 5'h3, addr 18'h00100), ack after 6 cycles with wb_dati 32'hDEADBEEF -> req_done[0] pulse, rsp_code 0, rsp_rdata DEADBEEF, pointer advances to 1.
- All 4 req_valid held, each ack after 2 cycles -> grants in order 0,1,2,3,0; wb_str low at least 1 cycle between transactions; no starvation.
- wb_err on the first 2 attempts, ack on the 3rd (MAX_RETRY=2) -> 2 GAP cycles observed, retry_count 2, rsp_code 0. With err on all 3 attempts -> req_error=1, rsp_code 1.
- No ack for TIMEOUT_CYCLES -> wb_reset high exactly 16 cycles, then req_done with rsp_code 2, timeout_count 1; the next requester is served normally afterwards.
- wb_ack and wb_err in the same cycle -> treated as an error (retry), rsp_rdata unchanged.
- reset asserted 3 cycles into ISSUE -> wb_str 0 next cycle, no req_done, counters 0, pointer 0; a fresh request then completes normally.

Source files
------------

// File: rtl/wb_link_arbiter_if.sv
// Requester-side and Wishbone-master-side signals of the link arbiter.
// "slave" is the arbiter's view; "master" is the view of the requesters plus the wb master.
interface wb_link_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [5*NREQ-1:0]    req_target;
    logic [18*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      req_done;
    logic                 req_error;
    logic [31:0]          rsp_rdata;
    logic [1:0]           rsp_code;

    logic                 wb_str;
    logic                 wb_we;
    logic [4:0]           wb_target;
    logic [17:0]          wb_addr;
    logic [31:0]          wb_dato;
    logic                 wb_reset;
    logic                 wb_ack;
    logic                 wb_err;
    logic [31:0]          wb_dati;

    modport slave (
        input  req_valid, req_we, req_target, req_addr, req_wdata,
        input  wb_ack, wb_err, wb_dati,
        output req_done, req_error, rsp_rdata, rsp_code,
        output wb_str, wb_we, wb_target, wb_addr, wb_dato, wb_reset
    );

    modport master (
        output req_valid, req_we, req_target, req_addr, req_wdata,
        output wb_ack, wb_err, wb_dati,
        input  req_done, req_error, rsp_rdata, rsp_code,
        input  wb_str, wb_we, wb_target, wb_addr, wb_dato, wb_reset
    );
endinterface

// File: rtl/wb_link_arbiter.sv
// Round-robin arbiter/sequencer for the single-transaction link master; grant->req_done = ack latency + 2 cycles.
// Requesters hold req_valid until req_done; one bus cycle at a time, retried on wb_err, timed out with a master reset.
module wb_link_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int MAX_RETRY      = 2,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic                clk_link,
    input  logic                reset,
    input  logic                enable,
    wb_link_arbiter_if.slave    bus,
    output logic                busy,
    output logic [2:0]          owner,
    output logic [15:0]         timeout_count,
    output logic [15:0]         retry_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, RECOVER} state_t;

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] REC_LAST  = 16'(RECOVER_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [2:0]  LAST_REQ  = 3'(NREQ - 1);

    state_t      state;
    logic [2:0]  ptr;
    logic [15:0] dur;
    logic [3:0]  retries;

    logic [7:0]  valid8;
    logic [7:0]  we8;
    logic [4:0]  tgt_a  [8];
    logic [17:0] addr_a [8];
    logic [31:0] wdat_a [8];

    logic        gnt_found;
    logic [2:0]  gnt_idx;
    logic        fin;
    logic [1:0]  fin_code;

    assign valid8 = 8'(bus.req_valid);
    assign we8    = 8'(bus.req_we);
    assign busy   = (state != IDLE);

    for (genvar i = 0; i < 8; i++) begin : g_fld
        if (i < NREQ) begin : g_on
            assign tgt_a[i]  = bus.req_target[5*i +: 5];
            assign addr_a[i] = bus.req_addr[18*i +: 18];
            assign wdat_a[i] = bus.req_wdata[32*i +: 32];
        end else begin : g_off
            assign tgt_a[i]  = '0;
            assign addr_a[i] = '0;
            assign wdat_a[i] = '0;
        end
    end

    // First valid requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && valid8[3'((int'(ptr) + k) % NREQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // wb_err wins over a simultaneous wb_ack.
    always_comb begin
        fin      = 1'b0;
        fin_code = 2'd0;
        case (state)
            ISSUE: begin
                if (bus.wb_err) begin
                    if (retries >= RETRY_MAX) begin
                        fin      = 1'b1;
                        fin_code = 2'd1;
                    end
                end else if (bus.wb_ack) begin
                    fin = 1'b1;
                end
            end
            RECOVER: begin
                if (dur == REC_LAST) begin
                    fin      = 1'b1;
                    fin_code = 2'd2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_link) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= 3'd0;
            dur            <= 16'd0;
            retries        <= 4'd0;
            owner          <= 3'd0;
            timeout_count  <= 16'd0;
            retry_count    <= 16'd0;
            bus.req_done   <= '0;
            bus.req_error  <= 1'b0;
            bus.rsp_code   <= 2'd0;
            bus.rsp_rdata  <= 32'd0;
            bus.wb_str     <= 1'b0;
            bus.wb_we      <= 1'b0;
            bus.wb_target  <= 5'd0;
            bus.wb_addr    <= 18'd0;
            bus.wb_dato    <= 32'd0;
            bus.wb_reset   <= 1'b0;
        end else begin
            bus.req_done  <= '0;
            bus.req_error <= 1'b0;
            bus.rsp_code  <= 2'd0;

            if (fin) begin
                bus.req_done  <= NREQ'(1) << owner;
                bus.req_error <= (fin_code != 2'd0);
                bus.rsp_code  <= fin_code;
                ptr           <= (owner == LAST_REQ) ? 3'd0 : owner + 3'd1;
                state         <= IDLE;
                bus.wb_str    <= 1'b0;
                bus.wb_reset  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // The requester still sees its req_valid high during the done pulse, so skip that cycle.
                    if (enable && gnt_found && !(|bus.req_done)) begin
                        owner         <= gnt_idx;
                        bus.wb_we     <= we8[gnt_idx];
                        bus.wb_target <= tgt_a[gnt_idx];
                        bus.wb_addr   <= addr_a[gnt_idx];
                        bus.wb_dato   <= wdat_a[gnt_idx];
                        retries       <= 4'd0;
                        dur           <= 16'd0;
                        bus.wb_str    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    dur <= dur + 16'd1;
                    if (bus.wb_err) begin
                        if (retries < RETRY_MAX) begin
                            retries    <= retries + 4'd1;
                            bus.wb_str <= 1'b0;
                            state      <= GAP;
                            if (retry_count != 16'hFFFF) retry_count <= retry_count + 16'd1;
                        end
                    end else if (bus.wb_ack) begin
                        if (!bus.wb_we) bus.rsp_rdata <= bus.wb_dati;
                    end else if (dur == TO_LAST) begin
                        bus.wb_str   <= 1'b0;
                        bus.wb_reset <= 1'b1;
                        dur          <= 16'd0;
                        state        <= RECOVER;
                        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
                    end
                end
                GAP: begin
                    bus.wb_str <= 1'b1;
                    dur        <= 16'd0;
                    state      <= ISSUE;
                end
                RECOVER: begin
                    dur <= dur + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_link_arbiter.sv
// Directed bench for wb_link_arbiter: expected completions are queued at issue time and
// checked by an independent monitor whenever req_done pulses.
module tb_wb_link_arbiter;
    logic        clk_link = 1'b0;
    logic        reset;
    logic        enable;
    logic        busy;
    logic [2:0]  owner;
    logic [15:0] timeout_count;
    logic [15:0] retry_count;

    always #5 clk_link = ~clk_link;

    wb_link_arbiter_if #(.NREQ(4)) bus ();

    wb_link_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(4095), .MAX_RETRY(2), .RECOVER_CYCLES(16)) dut (
        .clk_link      (clk_link),
        .reset         (reset),
        .enable        (enable),
        .bus           (bus),
        .busy          (busy),
        .owner         (owner),
        .timeout_count (timeout_count),
        .retry_count   (retry_count)
    );

    typedef struct {
        logic [2:0]  own;
        logic [1:0]  code;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          issue_cnt[4] = '{default: 0};
    int          done_cnt[4];
    logic [3:0]  drop = 4'b0000;
    int          ack_dly = 2;
    int          n_err = 0;
    logic        both = 1'b0;
    logic        no_ack = 1'b0;
    logic [31:0] key = 32'd0;
    int          t_done = 0;
    int          gap_cycles = 0;
    int          rst_cycles = 0;

    always @(posedge clk_link) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Requesters: valid while issued transactions are outstanding; reset aborts them.
    initial begin
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        forever begin
            @(negedge clk_link);
            for (int i = 0; i < 4; i++) begin
                if (reset) done_cnt[i] = issue_cnt[i];
                else if (bus.req_done[i]) done_cnt[i]++;
                bus.req_valid[i] = (issue_cnt[i] != done_cnt[i]) && !drop[i];
            end
        end
    end

    // Link master model: answers ack_dly cycles after each strobe rise, erroring the first n_err attempts.
    initial begin
        int  attempt;
        int  cyc;
        logic prev;
        attempt = 0; cyc = 0; prev = 1'b0;
        bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dati = 32'd0;
        forever begin
            @(negedge clk_link);
            bus.wb_ack  = 1'b0;
            bus.wb_err  = 1'b0;
            bus.wb_dati = 32'hBAD0BAD0;
            if (reset) begin
                attempt = 0;
                prev    = 1'b0;
            end else begin
                if (|bus.req_done) attempt = 0;
                if (bus.wb_str) begin
                    cyc = prev ? cyc + 1 : 0;
                    if (cyc == ack_dly && !no_ack) begin
                        if (attempt < n_err) begin
                            bus.wb_err = 1'b1;
                            bus.wb_ack = both;
                        end else begin
                            bus.wb_ack = 1'b1;
                        end
                        bus.wb_dati = key ^ {14'd0, bus.wb_addr};
                        attempt++;
                    end
                end
                prev = bus.wb_str;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_link);
            if (!reset) begin
                if (busy && !bus.wb_str && !bus.wb_reset) gap_cycles++;
                if (bus.wb_reset) rst_cycles++;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_link);
            if (!reset && bus.req_done != 4'b0) begin
                t_done = cycle;
                chk("str_low_at_done", 32'(bus.wb_str), 32'd0);
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: req_done=%b with nothing expected", bus.req_done);
                end else begin
                    e = sbq.pop_front();
                    chk("done_onehot", 32'(bus.req_done), 32'd1 << e.own);
                    chk("rsp_code", 32'(bus.rsp_code), 32'(e.code));
                    chk("req_error", 32'(bus.req_error), 32'(e.code != 2'd0));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int o, input int code, input logic [31:0] rd);
        exp_t e;
        e.own   = 3'(o);
        e.code  = 2'(code);
        e.rdata = rd;
        sbq.push_back(e);
    endfunction

    task automatic set_req(input int i, input logic we, input logic [4:0] tgt,
                           input logic [17:0] a, input logic [31:0] wd);
        bus.req_we[i]              = we;
        bus.req_target[i*5 +: 5]   = tgt;
        bus.req_addr[i*18 +: 18]   = a;
        bus.req_wdata[i*32 +: 32]  = wd;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_link);
    endtask

    task automatic wait_str(input string name, input int budget, output int t);
        int n;
        n = 0;
        while (!bus.wb_str && n < budget) begin
            @(negedge clk_link);
            n++;
        end
        t = cycle;
        vectors++;
        if (!bus.wb_str) begin
            miscompares++;
            $display("FAIL %s: wb_str still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    function automatic logic outstanding(input logic [3:0] m);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++)
            if (m[i] && issue_cnt[i] != done_cnt[i]) r = 1'b1;
        return r;
    endfunction

    task automatic wait_done(input string name, input logic [3:0] m, input int budget);
        int n;
        n = 0;
        while (outstanding(m) && n < budget) begin
            @(negedge clk_link);
            n++;
        end
        vectors++;
        if (outstanding(m)) begin
            miscompares++;
            $display("FAIL %s: transactions still outstanding after %0d cycles, expected none", name, budget);
        end
        @(negedge clk_link);
    endtask

    initial begin
        int          t_str;
        int          g0;
        int          r0;
        logic [31:0] exp_rdata;

        reset = 1'b1;
        enable = 1'b1;
        bus.req_we = '0; bus.req_target = '0; bus.req_addr = '0; bus.req_wdata = '0;
        exp_rdata = 32'd0;
        repeat (3) @(posedge clk_link);
        #1 reset = 1'b0;
        @(negedge clk_link);

        chk("rst_wb_str", 32'(bus.wb_str), 32'd0);
        chk("rst_wb_reset", 32'(bus.wb_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_timeouts", 32'(timeout_count), 32'd0);
        chk("rst_retries", 32'(retry_count), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_done", 32'(bus.req_done), 32'd0);

        // Single read from requester 0.
        key = 32'hDEADBFEF;
        ack_dly = 6;
        push(0, 0, 32'hDEADBEEF);
        exp_rdata = 32'hDEADBEEF;
        @(posedge clk_link); #1;
        set_req(0, 1'b0, 5'h03, 18'h00100, 32'd0);
        issue_cnt[0]++;
        wait_str("t1_str", 50, t_str);
        chk("t1_wb_target", 32'(bus.wb_target), 32'h3);
        chk("t1_wb_addr", 32'(bus.wb_addr), 32'h100);
        chk("t1_wb_we", 32'(bus.wb_we), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 4'b0001, 50);
        chk("t1_latency", 32'(t_done - t_str), 32'd7);

        // Pointer is now 1: requester 1 (write) wins over requester 0.
        key = 32'h5A5A0000;
        ack_dly = 2;
        push(1, 0, exp_rdata);
        push(0, 0, key ^ 32'h200);
        exp_rdata = key ^ 32'h200;
        @(posedge clk_link); #1;
        set_req(0, 1'b0, 5'h01, 18'h00200, 32'd0);
        set_req(1, 1'b1, 5'h02, 18'h00300, 32'h12345678);
        issue_cnt[0]++; issue_cnt[1]++;
        wait_str("t2_str", 50, t_str);
        chk("t2_owner", 32'(owner), 32'd1);
        chk("t2_wb_dato", bus.wb_dato, 32'h12345678);
        chk("t2_wb_we", 32'(bus.wb_we), 32'd1);
        wait_done("t2_done", 4'b0011, 100);

        // All four requesters, two transactions each: 1,2,3,0,1,2,3,0.
        for (int k = 0; k < 8; k++) begin
            int o;
            o = (1 + k) % 4;
            push(o, 0, key ^ 32'(o * 16 + 64));
        end
        exp_rdata = key ^ 32'h40;
        g0 = gap_cycles;
        @(posedge clk_link); #1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 5'(i + 4), 18'(i * 16 + 64), 32'd0);
            issue_cnt[i] += 2;
        end
        wait_done("t3_done", 4'b1111, 300);
        chk("t3_no_gaps", 32'(gap_cycles - g0), 32'd0);

        // Two errors then ack.
        n_err = 2;
        ack_dly = 1;
        push(2, 0, key ^ 32'h2A);
        exp_rdata = key ^ 32'h2A;
        g0 = gap_cycles;
        @(posedge clk_link); #1;
        set_req(2, 1'b0, 5'h0A, 18'h0002A, 32'd0);
        issue_cnt[2]++;
        wait_done("t4_done", 4'b0100, 100);
        chk("t4_retry_count", 32'(retry_count), 32'd2);
        chk("t4_gap_cycles", 32'(gap_cycles - g0), 32'd2);

        // Errors on every attempt.
        n_err = 3;
        push(3, 1, exp_rdata);
        g0 = gap_cycles;
        @(posedge clk_link); #1;
        set_req(3, 1'b0, 5'h0B, 18'h00033, 32'd0);
        issue_cnt[3]++;
        wait_done("t5_done", 4'b1000, 100);
        chk("t5_retry_count", 32'(retry_count), 32'd4);
        chk("t5_gap_cycles", 32'(gap_cycles - g0), 32'd2);

        // ack together with err counts as an error; read data must not be captured.
        both = 1'b1;
        push(0, 1, exp_rdata);
        @(posedge clk_link); #1;
        set_req(0, 1'b0, 5'h0C, 18'h00044, 32'd0);
        issue_cnt[0]++;
        wait_done("t6_done", 4'b0001, 100);
        chk("t6_retry_count", 32'(retry_count), 32'd6);
        chk("t6_rdata_kept", bus.rsp_rdata, exp_rdata);
        both = 1'b0;
        n_err = 0;

        // Timeout and recovery, then a normal transaction.
        no_ack = 1'b1;
        push(1, 2, exp_rdata);
        r0 = rst_cycles;
        @(posedge clk_link); #1;
        set_req(1, 1'b0, 5'h11, 18'h01111, 32'd0);
        issue_cnt[1]++;
        wait_str("t7_str", 50, t_str);
        wait_done("t7_done", 4'b0010, 6000);
        chk("t7_timeout_count", 32'(timeout_count), 32'd1);
        chk("t7_wb_reset_cycles", 32'(rst_cycles - r0), 32'd16);
        chk("t7_latency", 32'(t_done - t_str), 32'd4111);
        no_ack = 1'b0;
        ack_dly = 3;
        push(2, 0, key ^ 32'h2222);
        exp_rdata = key ^ 32'h2222;
        @(posedge clk_link); #1;
        set_req(2, 1'b0, 5'h12, 18'h02222, 32'd0);
        issue_cnt[2]++;
        wait_done("t7b_done", 4'b0100, 100);

        // Mid-transaction: enable low, owner drops valid, a non-owner changes its fields.
        ack_dly = 8;
        push(3, 0, exp_rdata);
        @(posedge clk_link); #1;
        set_req(3, 1'b1, 5'h1F, 18'h3FFFF, 32'hCAFEF00D);
        issue_cnt[3]++;
        wait_str("t8_str", 50, t_str);
        chk("t8_wb_dato", bus.wb_dato, 32'hCAFEF00D);
        chk("t8_wb_we", 32'(bus.wb_we), 32'd1);
        enable = 1'b0;
        drop[3] = 1'b1;
        push(0, 0, key ^ 32'hABC);
        set_req(0, 1'b0, 5'h00, 18'h00ABC, 32'd0);
        issue_cnt[0]++;
        tick(3);
        chk("t8_wb_addr_held", 32'(bus.wb_addr), 32'h3FFFF);
        chk("t8_wb_target_held", 32'(bus.wb_target), 32'h1F);
        chk("t8_wb_str_held", 32'(bus.wb_str), 32'd1);
        wait_done("t8_done", 4'b1000, 100);
        tick(5);
        chk("t8_no_grant_disabled", 32'(busy), 32'd0);
        drop = 4'b0000;
        enable = 1'b1;
        exp_rdata = key ^ 32'hABC;
        wait_done("t8b_done", 4'b0001, 100);

        // Reset 3 cycles into ISSUE.
        ack_dly = 20;
        @(posedge clk_link); #1;
        set_req(2, 1'b0, 5'h05, 18'h00555, 32'd0);
        issue_cnt[2]++;
        wait_str("t9_str", 50, t_str);
        tick(3);
        reset = 1'b1;
        @(negedge clk_link);
        chk("t9_wb_str", 32'(bus.wb_str), 32'd0);
        chk("t9_busy", 32'(busy), 32'd0);
        chk("t9_owner", 32'(owner), 32'd0);
        chk("t9_retries", 32'(retry_count), 32'd0);
        chk("t9_timeouts", 32'(timeout_count), 32'd0);
        chk("t9_rdata", bus.rsp_rdata, 32'd0);
        chk("t9_done", 32'(bus.req_done), 32'd0);
        @(posedge clk_link); #1 reset = 1'b0;
        exp_rdata = 32'd0;

        // Pointer back at 0: requester 0 before requester 1.
        ack_dly = 2;
        push(0, 0, key ^ 32'h777);
        push(1, 0, key ^ 32'h777);
        @(posedge clk_link); #1;
        set_req(0, 1'b0, 5'h07, 18'h00777, 32'd0);
        set_req(1, 1'b1, 5'h08, 18'h00888, 32'h0F0F0F0F);
        issue_cnt[0]++; issue_cnt[1]++;
        wait_str("t10_str", 50, t_str);
        chk("t10_owner", 32'(owner), 32'd0);
        wait_done("t10_done", 4'b0011, 100);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
